// File: rtl/perceptron_weight_update.sv
// Perceptron training datapath: latches one sample, computes the scaled error
// and updates the weights one lane per cycle and then the bias. The block owns
// the weight and bias storage that the forward path reads.
// Optional feature macro: PERCEPTRON_WEIGHT_UPDATE_SATURATE_EN. When it is
// defined, the error subtraction and every weight/bias addition saturate on
// signed overflow. When it is undefined, they wrap.
module perceptron_weight_update #(
   parameter int unsigned N_INPUTS = 4,
   parameter logic [63:0] LR       = 64'h0000_0000_1999_999A,
   parameter int unsigned IDX_W    = $clog2(N_INPUTS + 1)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [N_INPUTS*64-1:0]  x_flat,
   input  logic [63:0]             pred,
   input  logic [63:0]             target,
   input  logic                    ld_en,
   input  logic [IDX_W-1:0]        ld_idx,
   input  logic [63:0]             ld_data,
   input  logic                    clear_err,
   output logic [N_INPUTS*64-1:0]  w_flat,
   output logic [63:0]             bias,
   output logic                    busy,
   output logic                    done,
   output logic [31:0]             err_count
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_COMPUTE = 2'd1;
   localparam logic [1:0] ST_UPDATE  = 2'd2;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS);

   // Signed fixed-point multiply: 128-bit product, arithmetic shift by 32,
   // keep the low 64 bits.
   function automatic logic [63:0] sfp_mul(input logic [63:0] a, input logic [63:0] b);
      logic signed [127:0] p;
      p = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
      return 64'(p >>> 32);
   endfunction

   function automatic logic [63:0] sfp_add(input logic [63:0] a, input logic [63:0] b);
      logic [63:0] s;
      s = a + b;
`ifdef PERCEPTRON_WEIGHT_UPDATE_SATURATE_EN
      if ((a[63] == b[63]) && (s[63] != a[63]))
         s = a[63] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
`endif
      return s;
   endfunction

   function automatic logic [63:0] sfp_sub(input logic [63:0] a, input logic [63:0] b);
      logic [63:0] s;
      s = a - b;
`ifdef PERCEPTRON_WEIGHT_UPDATE_SATURATE_EN
      if ((a[63] != b[63]) && (s[63] != a[63]))
         s = a[63] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
`endif
      return s;
   endfunction

   logic [1:0]               state_q, state_d;
   logic [IDX_W-1:0]         idx_q, idx_d;
   logic [N_INPUTS*64-1:0]   x_q, x_d;
   logic [63:0]              pred_q, pred_d;
   logic [63:0]              target_q, target_d;
   logic [63:0]              delta_q, delta_d;
   logic [N_INPUTS*64-1:0]   w_q, w_d;
   logic [63:0]              bias_q, bias_d;
   logic [31:0]              cnt_q, cnt_d;
   logic                     done_q, done_d;

   logic [63:0]              err;
   logic [63:0]              x_sel;
   logic [63:0]              w_sel;
   logic [63:0]              mul_a;
   logic [63:0]              mul_b;
   logic [63:0]              mul_p;
   logic [63:0]              w_sum;

   // Select the feature and weight lane addressed by the update index.
   always_comb begin
      x_sel = '0;
      w_sel = '0;
      for (int unsigned i = 0; i < N_INPUTS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            x_sel = x_q[i*64 +: 64];
            w_sel = w_q[i*64 +: 64];
         end
      end
   end

   // One shared multiplier: LR*err in Compute and delta*x[idx] in Update.
   always_comb begin
      err   = sfp_sub(target_q, pred_q);
      mul_a = (state_q == ST_COMPUTE) ? LR  : delta_q;
      mul_b = (state_q == ST_COMPUTE) ? err : x_sel;
      mul_p = sfp_mul(mul_a, mul_b);
      w_sum = sfp_add(w_sel, mul_p);
   end

   // Next-state logic: handshake, loads, error scaling and the per-lane update.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      x_d      = x_q;
      pred_d   = pred_q;
      target_d = target_q;
      delta_d  = delta_q;
      w_d      = w_q;
      bias_d   = bias_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // A load in the same cycle as an accept lands first, so the
            // following Update builds on the loaded value.
            if (ld_en && (ld_idx <= LAST_IDX)) begin
               if (ld_idx == LAST_IDX) begin
                  bias_d = ld_data;
               end else begin
                  for (int unsigned i = 0; i < N_INPUTS; i++)
                     if (ld_idx == IDX_W'(i)) w_d[i*64 +: 64] = ld_data;
               end
            end
            if (in_valid) begin
               x_d      = x_flat;
               pred_d   = pred;
               target_d = target;
               state_d  = ST_COMPUTE;
            end
         end
         ST_COMPUTE: begin
            delta_d = mul_p;
            if (err == '0) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else begin
               if (cnt_q != '1) cnt_d = cnt_q + 32'd1;
               idx_d   = '0;
               state_d = ST_UPDATE;
            end
         end
         ST_UPDATE: begin
            if (idx_q < LAST_IDX) begin
               for (int unsigned i = 0; i < N_INPUTS; i++)
                  if (idx_q == IDX_W'(i)) w_d[i*64 +: 64] = w_sum;
               idx_d = idx_q + IDX_W'(1);
            end else begin
               bias_d  = sfp_add(bias_q, delta_q);
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (clear_err) cnt_d = '0;
   end

   // State and storage registers; reset discards any in-flight sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         x_q      <= '0;
         pred_q   <= '0;
         target_q <= '0;
         delta_q  <= '0;
         w_q      <= '0;
         bias_q   <= '0;
         cnt_q    <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         x_q      <= x_d;
         pred_q   <= pred_d;
         target_q <= target_d;
         delta_q  <= delta_d;
         w_q      <= w_d;
         bias_q   <= bias_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign done      = done_q;
   assign w_flat    = w_q;
   assign bias      = bias_q;
   assign err_count = cnt_q;

endmodule

// File: tb/tb_perceptron_weight_update.sv
// Directed bench for perceptron_weight_update. A behavioural model predicts
// the visible weights, bias, counter and handshake outputs every cycle. Literal
// checks pin the model to hand-computed values.
module tb_perceptron_weight_update;

   localparam int unsigned N = 4;
   localparam int unsigned IW = 3;
   localparam logic [63:0] TB_LR = 64'h0000_0000_8000_0000;
   localparam logic [63:0] ONE   = 64'h0000_0001_0000_0000;

   logic              clk;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [N*64-1:0]   x_flat;
   logic [63:0]       pred;
   logic [63:0]       target;
   logic              ld_en;
   logic [IW-1:0]     ld_idx;
   logic [63:0]       ld_data;
   logic              clear_err;
   logic [N*64-1:0]   w_flat;
   logic [63:0]       bias;
   logic              busy;
   logic              done;
   logic [31:0]       err_count;

   int n_checks = 0;
   int n_pass   = 0;

   perceptron_weight_update #(.N_INPUTS(N), .LR(TB_LR)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .x_flat(x_flat), .pred(pred), .target(target), .ld_en(ld_en),
      .ld_idx(ld_idx), .ld_data(ld_data), .clear_err(clear_err),
      .w_flat(w_flat), .bias(bias), .busy(busy), .done(done),
      .err_count(err_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout");
      $fatal(1, "simulation time limit reached");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // ---------------- behavioural model ----------------
   function automatic logic [63:0] m_mul(input logic [63:0] a, input logic [63:0] b);
      logic signed [127:0] sa, sb, p;
      sa = $signed(a);
      sb = $signed(b);
      p  = sa * sb;
      return p[95:32];
   endfunction

   function automatic logic [63:0] m_add(input logic [63:0] a, input logic [63:0] b);
      logic signed [64:0] s;
      s = $signed({a[63], a}) + $signed({b[63], b});
`ifdef PERCEPTRON_WEIGHT_UPDATE_SATURATE_EN
      if (s[64] != s[63]) return s[64] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
`endif
      return s[63:0];
   endfunction

   function automatic logic [63:0] m_sub(input logic [63:0] a, input logic [63:0] b);
      logic signed [64:0] s;
      s = $signed({a[63], a}) - $signed({b[63], b});
`ifdef PERCEPTRON_WEIGHT_UPDATE_SATURATE_EN
      if (s[64] != s[63]) return s[64] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
`endif
      return s[63:0];
   endfunction

   logic [63:0] ew [N];
   logic [63:0] eb;
   logic [31:0] ecnt;
   logic        edone;
   int          since_accept;   // edges elapsed since accept, 0 = idle
   logic [63:0] m_err, m_delta;
   logic [63:0] m_prod [N];

   task automatic model_reset();
      for (int i = 0; i < N; i++) ew[i] = '0;
      eb = '0;
      ecnt = '0;
      edone = 1'b0;
      since_accept = 0;
   endtask

   // Advance the model over the coming clock edge, using inputs stable now.
   task automatic model_step();
      edone = 1'b0;
      if (since_accept == 0) begin
         if (ld_en && (ld_idx <= IW'(N))) begin
            if (ld_idx == IW'(N)) eb = ld_data;
            else ew[ld_idx] = ld_data;
         end
         if (in_valid) begin
            m_err   = m_sub(target, pred);
            m_delta = m_mul(TB_LR, m_err);
            for (int i = 0; i < N; i++) m_prod[i] = m_mul(m_delta, x_flat[i*64 +: 64]);
            since_accept = 1;
         end
      end else if (since_accept == 1) begin
         if (m_err == 64'd0) begin
            since_accept = 0;
            edone = 1'b1;
         end else begin
            if (ecnt != 32'hFFFF_FFFF) ecnt = ecnt + 1;
            since_accept = 2;
         end
      end else if (since_accept <= N + 1) begin
         ew[since_accept-2] = m_add(ew[since_accept-2], m_prod[since_accept-2]);
         since_accept++;
      end else begin
         eb = m_add(eb, m_delta);
         since_accept = 0;
         edone = 1'b1;
      end
      if (clear_err) ecnt = '0;
   endtask

   // Compare process: every falling edge, DUT outputs against the model.
   initial begin : monitor
      forever begin
         @(negedge clk);
         if (!rst_n) model_reset();
         chk("in_ready", in_ready, since_accept == 0);
         chk("busy", busy, since_accept != 0);
         chk("done", done, edone);
         chk("err_count", err_count, ecnt);
         chk("bias", bias, eb);
         for (int i = 0; i < N; i++) chk($sformatf("w%0d", i), w_flat[i*64 +: 64], ew[i]);
         if (rst_n) model_step();
      end
   end

   // ---------------- driver ----------------
   task automatic set_x(input logic [63:0] x0, input logic [63:0] x1,
                        input logic [63:0] x2, input logic [63:0] x3);
      x_flat = {x3, x2, x1, x0};
   endtask

   // Presents the already-set sample and returns 1 time unit after the accept edge.
   task automatic send(input logic hold);
      logic ok;
      ok = 1'b0;
      in_valid = 1'b1;
      for (int c = 0; c < 100 && !ok; c++) begin
         @(negedge clk);
         if (in_ready) ok = 1'b1;
         @(posedge clk);
         #1;
      end
      if (!hold) in_valid = 1'b0;
      chk("accept_seen", ok, 1'b1);
   endtask

   task automatic wait_done(output int lat);
      logic got;
      got = 1'b0;
      lat = 0;
      for (int c = 0; c < 50 && !got; c++) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (done) got = 1'b1;
      end
      chk("done_seen", got, 1'b1);
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [IW-1:0] idx, input logic [63:0] data);
      ld_en = 1'b1;
      ld_idx = idx;
      ld_data = data;
      @(posedge clk);
      #1;
      ld_en = 1'b0;
   endtask

   initial begin : driver
      int lat;
      int edges;
      rst_n = 1'b0;
      in_valid = 1'b0;
      ld_en = 1'b0;
      ld_idx = '0;
      ld_data = '0;
      clear_err = 1'b0;
      pred = '0;
      target = '0;
      x_flat = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Reset in the middle of Update discards the partial update.
      set_x(ONE, ONE, ONE, ONE); pred = '0; target = ONE;
      send(1'b0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      chk("rst_w", w_flat, '0);
      chk("rst_bias", bias, '0);
      chk("rst_cnt", err_count, '0);
      chk("rst_ready", in_ready, 1'b1);
      chk("rst_done", done, 1'b0);
      chk("rst_busy", busy, 1'b0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic update with LR=0.5 and error 1.0.
      set_x(ONE, 64'h0000_0002_0000_0000, 64'hFFFF_FFFF_0000_0000, 64'h0000_0003_0000_0000);
      pred = '0; target = ONE;
      send(1'b0);
      wait_done(lat);
      chk("lat_nonzero", lat, 6);
      chk("t2_w0", w_flat[0*64 +: 64], 64'h0000_0000_8000_0000);
      chk("t2_w1", w_flat[1*64 +: 64], 64'h0000_0001_0000_0000);
      chk("t2_w2", w_flat[2*64 +: 64], 64'hFFFF_FFFF_8000_0000);
      chk("t2_w3", w_flat[3*64 +: 64], 64'h0000_0001_8000_0000);
      chk("t2_bias", bias, 64'h0000_0000_8000_0000);
      chk("t2_cnt", err_count, 32'd1);

      // Zero error: no update, short latency.
      pred = ONE; target = ONE;
      send(1'b0);
      wait_done(lat);
      chk("lat_zero", lat, 1);
      chk("t3_cnt", err_count, 32'd1);
      chk("t3_w1", w_flat[1*64 +: 64], 64'h0000_0001_0000_0000);

      // Back-to-back samples with in_valid held high.
      set_x(ONE, ONE, ONE, ONE); pred = '0; target = ONE;
      send(1'b1);
      set_x(ONE, '0, '0, '0); pred = '0; target = 64'hFFFF_FFFF_0000_0000;
      edges = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (in_ready) break;
         @(posedge clk);
         edges++;
      end
      chk("b2b_gap", edges, 6);
      chk("b2b_done_with_ready", done, 1'b1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      wait_done(lat);
      chk("b2b_lat", lat, 6);
      chk("b2b_cnt", err_count, 32'd3);

      // Direct loads.
      load(3'd4, 64'h0000_0002_0000_0000);
      @(negedge clk);
      chk("ld_bias", bias, 64'h0000_0002_0000_0000);
      @(posedge clk);
      #1;
      load(3'd5, 64'hDEAD_BEEF_0000_0000);
      @(negedge clk);
      chk("ld_oob_bias", bias, 64'h0000_0002_0000_0000);
      @(posedge clk);
      #1;

      // Load ignored during Update; clear coincides with the increment.
      set_x(ONE, ONE, ONE, ONE); pred = '0; target = ONE;
      send(1'b0);
      clear_err = 1'b1;
      @(posedge clk);
      #1 clear_err = 1'b0;
      load(3'd0, 64'h0000_1234_0000_0000);
      wait_done(lat);
      chk("clr_cnt", err_count, 32'd0);

      // Overflow on the weight addition, with a load accepted in the same cycle.
      ld_en = 1'b1; ld_idx = 3'd0; ld_data = 64'h7FFF_FFFF_0000_0000;
      set_x(ONE, '0, '0, '0); pred = '0; target = 64'h0000_0002_0000_0000;
      send(1'b0);
      ld_en = 1'b0;
      wait_done(lat);
`ifdef PERCEPTRON_WEIGHT_UPDATE_SATURATE_EN
      chk("ovf_w0", w_flat[0*64 +: 64], 64'h7FFF_FFFF_FFFF_FFFF);
`else
      chk("ovf_w0", w_flat[0*64 +: 64], 64'h8000_0000_0000_0000);
`endif

      repeat (2) @(posedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
